// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: steers the PC mux and drives the stack pop/push strobes
// for boot, return-from-call and interrupt entry.
module fetch_controller #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       branch_taken,
    input  logic       ret_req,
    input  logic       int_req,
    output logic       pc_enable,
    output logic [1:0] pc_selection,
    output logic       pop_pc_low_sig,
    output logic       pop_pc_high_sig,
    output logic       push_pc_low_sig,
    output logic       push_pc_high_sig,
    output logic       interrupt,
    output logic       int_ack,
    output logic       flush,
    output logic       busy
);

    typedef enum logic [2:0] {
        BOOT          = 3'd0,
        RUN           = 3'd1,
        POP_LOW       = 3'd2,
        POP_HIGH      = 3'd3,
        INT_SAVE_LOW  = 3'd4,
        INT_SAVE_HIGH = 3'd5,
        INT_VECTOR    = 3'd6
    } state_t;

    localparam logic [1:0] SEL_NEXT   = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_FIRST  = 2'b10;
    localparam logic [1:0] SEL_VECTOR = 2'b11;

    state_t r_state;
    state_t w_next;
    logic   r_int_pending;

    always_comb begin
        w_next           = r_state;
        pc_enable        = 1'b0;
        pc_selection     = SEL_NEXT;
        pop_pc_low_sig   = 1'b0;
        pop_pc_high_sig  = 1'b0;
        push_pc_low_sig  = 1'b0;
        push_pc_high_sig = 1'b0;
        interrupt        = 1'b0;
        int_ack          = 1'b0;
        flush            = 1'b0;
        busy             = 1'b1;

        unique case (r_state)
            BOOT: begin
                pc_enable    = 1'b1;
                pc_selection = SEL_FIRST;
                flush        = 1'b1;
                w_next       = RUN;
            end
            RUN: begin
                busy = 1'b0;
                // Priority: stall > ret > branch > pending interrupt > sequential
                if (stall) begin
                    pc_enable = 1'b0;
                end else if (ret_req) begin
                    flush  = 1'b1;
                    w_next = POP_LOW;
                end else if (branch_taken) begin
                    pc_enable    = 1'b1;
                    pc_selection = SEL_BRANCH;
                    flush        = 1'b1;
                end else if (r_int_pending) begin
                    flush  = 1'b1;
                    w_next = INT_SAVE_LOW;
                end else begin
                    pc_enable = 1'b1;
                end
            end
            POP_LOW: begin
                pop_pc_low_sig = 1'b1;
                w_next         = POP_HIGH;
            end
            POP_HIGH: begin
                pop_pc_high_sig = 1'b1;
                w_next          = RUN;
            end
            INT_SAVE_LOW: begin
                push_pc_low_sig = 1'b1;
                w_next          = INT_SAVE_HIGH;
            end
            INT_SAVE_HIGH: begin
                push_pc_high_sig = 1'b1;
                w_next           = INT_VECTOR;
            end
            INT_VECTOR: begin
                pc_enable    = 1'b1;
                pc_selection = SEL_VECTOR;
                interrupt    = 1'b1;
                int_ack      = 1'b1;
                flush        = 1'b1;
                w_next       = RUN;
            end
            default: begin
                w_next = BOOT;
            end
        endcase

        // Reset is synchronous, but the outputs already present the boot vector
        // while it is held so the PC latches 0x20 regardless of the old state.
        if (rst) begin
            w_next           = BOOT;
            pc_enable        = 1'b1;
            pc_selection     = SEL_FIRST;
            pop_pc_low_sig   = 1'b0;
            pop_pc_high_sig  = 1'b0;
            push_pc_low_sig  = 1'b0;
            push_pc_high_sig = 1'b0;
            interrupt        = 1'b0;
            int_ack          = 1'b0;
            flush            = 1'b1;
            busy             = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= BOOT;
            r_int_pending <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_int_pending <= int_req | (r_int_pending & (r_state != INT_VECTOR));
        end
    end

    // The stack is addressed in two 16-bit halves, so the PC must be 32 bits wide.
    a_pc_width: assert property (@(posedge clk) ADDR_WIDTH == 32);

    a_strobe_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0({pop_pc_low_sig, pop_pc_high_sig, push_pc_low_sig, push_pc_high_sig}));

    a_busy_state: assert property (@(posedge clk) disable iff (rst)
        busy == (r_state != RUN));

    a_no_pe_on_stack: assert property (@(posedge clk) disable iff (rst)
        (pop_pc_low_sig | pop_pc_high_sig | push_pc_low_sig | push_pc_high_sig) |-> !pc_enable);

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized bench for fetch_controller: a queue-of-scripted-cycles reference model
// predicts every output cycle by cycle.
module tb_fetch_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic       branch_taken = 1'b0;
    logic       ret_req = 1'b0;
    logic       int_req = 1'b0;
    logic       pc_enable;
    logic [1:0] pc_selection;
    logic       pop_pc_low_sig, pop_pc_high_sig;
    logic       push_pc_low_sig, push_pc_high_sig;
    logic       interrupt, int_ack, flush, busy;

    fetch_controller #(.ADDR_WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .ret_req         (ret_req),
        .int_req         (int_req),
        .pc_enable       (pc_enable),
        .pc_selection    (pc_selection),
        .pop_pc_low_sig  (pop_pc_low_sig),
        .pop_pc_high_sig (pop_pc_high_sig),
        .push_pc_low_sig (push_pc_low_sig),
        .push_pc_high_sig(push_pc_high_sig),
        .interrupt       (interrupt),
        .int_ack         (int_ack),
        .flush           (flush),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int ack_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Output vector: {pe, sel[1:0], flush, busy, popl, poph, pushl, pushh, intr, ack}
    function automatic logic [10:0] ov(input bit pe, input bit [1:0] sel, input bit fl,
                                       input bit bz, input bit [3:0] stk, input bit ir, input bit ak);
        return {pe, sel, fl, bz, stk, ir, ak};
    endfunction

    localparam logic [10:0] O_BOOT  = 11'b1_10_1_1_0000_0_0;
    localparam logic [10:0] O_SEQ   = 11'b1_00_0_0_0000_0_0;
    localparam logic [10:0] O_STALL = 11'b0_00_0_0_0000_0_0;
    localparam logic [10:0] O_KILL  = 11'b0_00_1_0_0000_0_0;
    localparam logic [10:0] O_BR    = 11'b1_01_1_0_0000_0_0;
    localparam logic [10:0] O_POPL  = 11'b0_00_0_1_1000_0_0;
    localparam logic [10:0] O_POPH  = 11'b0_00_0_1_0100_0_0;
    localparam logic [10:0] O_PUSHL = 11'b0_00_0_1_0010_0_0;
    localparam logic [10:0] O_PUSHH = 11'b0_00_0_1_0001_0_0;
    localparam logic [10:0] O_VEC   = 11'b1_11_1_1_0000_1_1;

    // Model: when the script queue is empty the controller is free-running;
    // otherwise it replays the queued multi-cycle sequence.
    logic [10:0] script[$];
    bit          pend = 1'b0;

    task automatic step(input bit r, input bit s, input bit b, input bit t, input bit q);
        logic [10:0] exp, obs;
        @(negedge clk);
        rst = r; stall = s; branch_taken = b; ret_req = t; int_req = q;
        #2;
        obs = {pc_enable, pc_selection, flush, busy, pop_pc_low_sig, pop_pc_high_sig,
               push_pc_low_sig, push_pc_high_sig, interrupt, int_ack};
        if (r) begin
            exp = O_BOOT;
            script.delete();
            script.push_back(O_BOOT);
            pend = 1'b0;
        end else if (script.size() != 0) begin
            exp  = script.pop_front();
            pend = q | (pend & !exp[1]);
        end else begin
            if (s) exp = O_STALL;
            else if (t) begin
                exp = O_KILL;
                script.push_back(O_POPL);
                script.push_back(O_POPH);
            end else if (b) exp = O_BR;
            else if (pend) begin
                exp = O_KILL;
                script.push_back(O_PUSHL);
                script.push_back(O_PUSHH);
                script.push_back(O_VEC);
            end else exp = O_SEQ;
            pend = pend | q;
        end
        chk("outputs", 32'(obs), 32'(exp));
        chk("strobe_onehot0", 32'($onehot0(obs[5:2])), 32'(1));
        chk("pe_during_stack", 32'((|obs[5:2]) & obs[10]), 32'(0));
        if (int_ack) ack_cnt++;
    endtask

    initial begin
        int acks_before;
        // Reset, boot, then sequential fetch
        repeat (3) step(1, 0, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0, 0);
        // Return: flush, pop low, pop high, back to RUN
        step(0, 0, 0, 1, 0);
        repeat (4) step(0, 0, 0, 0, 0);
        // Interrupt pulse hidden under a 3-cycle stall
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        repeat (6) step(0, 0, 0, 0, 0);
        // Branch and interrupt in the same cycle: branch first
        step(0, 0, 1, 0, 1);
        repeat (6) step(0, 0, 0, 0, 0);
        // Reset during INT_SAVE_HIGH must abort the vector and its ack
        acks_before = ack_cnt;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (8) step(0, 0, 0, 0, 0);
        chk("no_ack_after_abort", 32'(ack_cnt), 32'(acks_before));
        // Inputs ignored in non-RUN states, and an int_req during INT_VECTOR re-arms
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0);
        step(0, 1, 1, 1, 0);
        step(0, 0, 1, 0, 1);
        repeat (8) step(0, 0, 0, 0, 0);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 11) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
